if_prefetch_stage: RTL



---
 rtl/if_prefetch_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//   Instruction-fetch stage with a decoupled instruction-memory port and a
//   DEPTH-entry prefetch queue. Keeps fetching while the pipeline is frozen
//   until the queue is full. A taken branch flushes the queue and discards
//   the response of any request still in flight.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active-low
//   Branch_taken  redirect request from a later stage
//   BranchAdder   redirect target address
//   freeze        downstream stall; the queue head is not consumed
//   imem_req      fetch request valid (combinational)
//   imem_addr     fetch address
//   imem_gnt      request accepted this cycle
//   imem_rvalid   response valid (in order, at most one outstanding)
//   imem_rdata    response instruction
//   valid         queue head holds an instruction
//   PC            head's fetch address + PC_STEP (0 when empty)
//   instruction   head instruction (0 when empty)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no request outstanding
// ST_WAIT | one request outstanding, its response is pushed into the queue
// ST_DROP | one request outstanding, its response is discarded (flushed)
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Branch_taken,
    input  logic [ADDR_W-1:0]  BranchAdder,
    input  logic               freeze,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               valid,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] instruction
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  req_pc;
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    logic push;
    logic pop;
    logic issue;

    assign valid = (count != '0);
    assign pop   = valid && !freeze && !Branch_taken;
    assign push  = imem_rvalid && (state == ST_WAIT) && !Branch_taken;

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // A new request is only raised when its response is guaranteed a slot,
    // counting the entry that may be pushed this same cycle. The rst term
    // keeps the request low for the whole time reset is held.
    assign imem_req = rst && !Branch_taken
                      && (count_next < CNT_W'(DEPTH))
                      && ((state == ST_IDLE) || ((state == ST_WAIT) && imem_rvalid));
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;

    assign PC          = valid ? q_pc[rd_ptr]    : '0;
    assign instruction = valid ? q_instr[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (Branch_taken) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= BranchAdder;
            case (state)
                ST_WAIT: state <= imem_rvalid ? ST_IDLE : ST_DROP;
                ST_DROP: state <= imem_rvalid ? ST_IDLE : ST_DROP;
                default: state <= ST_IDLE;
            endcase
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                state    <= ST_WAIT;
            end else begin
                case (state)
                    ST_WAIT: if (imem_rvalid) state <= ST_IDLE;
                    ST_DROP: if (imem_rvalid) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only read when count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= req_pc + ADDR_W'(PC_STEP);
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule
